mult_prod_accum: RTL and testbench



---
 rtl/mult_prod_accum.sv | 96 +++++++++
 tb/tb_mult_prod_accum.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_prod_accum.sv
// Frame accumulator behind the 8x8 multiplier: sums valid/ready products per frame and
// holds the saturating sum, frame length and overflow flag until the sink takes them.
module mult_prod_accum #(
    parameter int unsigned PROD_W  = 16,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  frame_len,
    output logic              overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

    logic [1:0]       state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] len, len_next;
    logic             ovf, ovf_next;

    logic             accept;
    logic             in_frame;
    logic [ACC_W-1:0] acc_base;
    logic             ovf_base;
    logic [CNT_W-1:0] len_inc;
    logic [ACC_W:0]   sum;
    logic             closing;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign in_frame  = (state == ACCUM);

    // A product accepted in IDLE starts a fresh frame, so it adds onto zero.
    always_comb begin
        acc_base = in_frame ? acc : '0;
        ovf_base = in_frame ? ovf : 1'b0;
        len_inc  = in_frame ? (len + CNT_W'(1)) : CNT_W'(1);
        sum      = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        closing  = in_last || (len_inc == LEN_MAX);
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        len_next   = len;
        ovf_next   = ovf;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_next   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                    ovf_next   = ovf_base | sum[ACC_W];
                    len_next   = len_inc;
                    state_next = closing ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            len   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            len   <= len_next;
            ovf   <= ovf_next;
        end
    end

    assign acc_out   = acc;
    assign frame_len = len;
    assign overflow  = ovf;

endmodule

// File: tb/tb_mult_prod_accum.sv
// Bench for mult_prod_accum: a 24-bit and a 17-bit accumulator share stimulus and are
// checked every cycle against a true-sum frame model plus literal expectations.
module tb_mult_prod_accum;

    localparam int unsigned MAX_LEN = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, overflow_a;
    logic [23:0] acc_a;
    logic [8:0]  len_a;
    logic        in_ready_b, out_valid_b, overflow_b;
    logic [16:0] acc_b;
    logic [8:0]  len_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_prod_accum dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .prod      (prod),
        .in_last   (in_last),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .acc_out   (acc_a),
        .frame_len (len_a),
        .overflow  (overflow_a)
    );

    mult_prod_accum #(.ACC_W(17)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .prod      (prod),
        .in_last   (in_last),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .acc_out   (acc_b),
        .frame_len (len_b),
        .overflow  (overflow_b)
    );

    // Model: exact (unbounded) frame sum; saturation is applied only when comparing.
    logic    m_hold, m_open;
    longint  m_sum;
    int      m_len;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold <= 1'b0;
            m_open <= 1'b0;
            m_sum  <= 0;
            m_len  <= 0;
        end else if (m_hold) begin
            if (out_ready) m_hold <= 1'b0;
        end else if (in_valid) begin
            longint s;
            int     n;
            s = (m_open ? m_sum : 0) + longint'(prod);
            n = (m_open ? m_len : 0) + 1;
            m_sum <= s;
            m_len <= n;
            if (in_last || n == MAX_LEN) begin
                m_hold <= 1'b1;
                m_open <= 1'b0;
            end else begin
                m_open <= 1'b1;
            end
        end
    end

    function automatic longint sat(input longint s, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (s > mx) ? mx : s;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_a", longint'(in_ready_a), longint'(!m_hold));
            chk("in_ready_b", longint'(in_ready_b), longint'(!m_hold));
            chk("out_valid_a", longint'(out_valid_a), longint'(m_hold));
            chk("out_valid_b", longint'(out_valid_b), longint'(m_hold));
            if (m_hold) begin
                chk("acc_a", longint'(acc_a), sat(m_sum, 24));
                chk("acc_b", longint'(acc_b), sat(m_sum, 17));
                chk("len_a", longint'(len_a), longint'(m_len));
                chk("len_b", longint'(len_b), longint'(m_len));
                chk("ovf_a", longint'(overflow_a), longint'(m_sum > sat(m_sum, 24)));
                chk("ovf_b", longint'(overflow_b), longint'(m_sum > sat(m_sum, 17)));
            end
        end
    end

    // Apply inputs for the next rising edge, then settle 1 time unit past it.
    task automatic drive(input logic v, input logic [15:0] p, input logic l, input logic r);
        in_valid  = v;
        prod      = p;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_acc", longint'(acc_a), 0);
        chk("rst_len", longint'(len_a), 0);
        chk("rst_valid", longint'(out_valid_a), 0);
        chk("rst_ovf", longint'(overflow_a), 0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Three-product frame, sink ready
        drive(1, 10, 0, 1);
        drive(1, 20, 0, 1);
        drive(1, 30, 1, 1);
        chk("t1_valid", longint'(out_valid_a), 1);
        chk("t1_acc", longint'(acc_a), 60);
        chk("t1_len", longint'(len_a), 3);
        chk("t1_ovf", longint'(overflow_a), 0);
        drive(0, 0, 0, 1);
        chk("t1_release", longint'(out_valid_a), 0);

        // Single-item frame
        drive(1, 16'd65025, 1, 0);
        chk("t2_acc", longint'(acc_a), 65025);
        chk("t2_len", longint'(len_a), 1);
        chk("t2_ready", longint'(in_ready_a), 0);
        drive(0, 0, 0, 1);

        // Backpressure with inputs that must be ignored
        drive(1, 10, 0, 0);
        drive(1, 20, 0, 0);
        drive(1, 30, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 99, 0, 0);
            chk("t3_ready", longint'(in_ready_a), 0);
            chk("t3_valid", longint'(out_valid_a), 1);
            chk("t3_acc", longint'(acc_a), 60);
        end
        drive(1, 99, 0, 1);
        chk("t3_idle", longint'(out_valid_a), 0);
        drive(1, 4, 1, 0);
        chk("t3_clean_acc", longint'(acc_a), 4);
        chk("t3_clean_len", longint'(len_a), 1);
        drive(0, 0, 0, 1);

        // Auto-close at MAX_LEN
        for (int i = 0; i < 256; i++) drive(1, 16'd65025, 0, 0);
        chk("t4_valid", longint'(out_valid_a), 1);
        chk("t4_acc", longint'(acc_a), 16646400);
        chk("t4_len", longint'(len_a), 256);
        chk("t4_ovf", longint'(overflow_a), 0);
        chk("t4_acc17", longint'(acc_b), 131071);
        drive(0, 0, 0, 1);

        // Saturation on the 17-bit instance, then a clean frame
        drive(1, 16'd65025, 0, 0);
        drive(1, 16'd65025, 0, 0);
        drive(1, 16'd65025, 1, 0);
        chk("t5_acc17", longint'(acc_b), 131071);
        chk("t5_ovf17", longint'(overflow_b), 1);
        chk("t5_acc24", longint'(acc_a), 195075);
        drive(0, 0, 0, 1);
        drive(1, 5, 1, 0);
        chk("t5_next_acc", longint'(acc_b), 5);
        chk("t5_next_ovf", longint'(overflow_b), 0);
        drive(0, 0, 0, 1);

        // Reset mid-frame
        drive(1, 40, 0, 1);
        drive(1, 50, 0, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("t6_acc", longint'(acc_a), 0);
        chk("t6_valid", longint'(out_valid_a), 0);
        chk("t6_ready", longint'(in_ready_a), 1);
        rst = 1'b0;
        drive(1, 7, 1, 0);
        chk("t6_acc7", longint'(acc_a), 7);
        chk("t6_len", longint'(len_a), 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
